// File: rtl/rdma_meta_rx_demux_q.sv
// Purpose: steers RDMA RX metadata words to one of N_CH per-region FIFOs by VFID field.
// Latency: 1 cycle; a word accepted at edge t is visible on m_meta_valid after edge t.
// Backpressure: DROP_MODE=0 stalls s_meta_ready when the target queue is full; DROP_MODE=1 accepts and drops.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_meta_*              input stream (valid/ready/data)
//   m_meta_*              per-channel output streams, channel i at [i*DATA_BITS +: DATA_BITS]
//   vfid                  VFID field of the current input word (combinational)
//   fill                  per-channel occupancy, (log2(DEPTH)+1) bits per channel
//   drop_cnt, drop_cnt_clr saturating count of dropped words and its synchronous clear

// Purpose: generic circular FIFO with registered occupancy count.
// Latency: 1 cycle from write to rd_vld; read data is the head entry, no bypass.
// Backpressure: writes are ignored while full; rd_vld holds until rd_rdy pops the head.
module meta_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 16
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     full,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full   = (cnt == CNT_W'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign wr_en  = wr_vld & ~full;
    assign rd_en  = rd_vld & rd_rdy;

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module rdma_meta_rx_demux_q #(
    parameter int N_CH      = 4,
    parameter int DATA_BITS = 40,
    parameter int VFID_LSB  = 0,
    parameter int VFID_BITS = 4,
    parameter int DEPTH     = 16,
    parameter int DROP_MODE = 0
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_meta_valid,
    output logic                                  s_meta_ready,
    input  logic [DATA_BITS-1:0]                  s_meta_data,
    output logic [N_CH-1:0]                       m_meta_valid,
    input  logic [N_CH-1:0]                       m_meta_ready,
    output logic [N_CH*DATA_BITS-1:0]             m_meta_data,
    output logic [VFID_BITS-1:0]                  vfid,
    output logic [N_CH*($clog2(DEPTH)+1)-1:0]     fill,
    output logic [31:0]                           drop_cnt,
    input  logic                                  drop_cnt_clr
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N_CH-1:0] full;
    logic [N_CH-1:0] push;
    logic            tgt_ok;
    logic            full_sel;
    logic            in_acc;
    logic            drop;

    assign vfid   = s_meta_data[VFID_LSB +: VFID_BITS];
    assign tgt_ok = (32'(vfid) < 32'(N_CH));

    // Full flag of the addressed channel; 0 for an out-of-range VFID so such words
    // are always accepted (and then dropped).
    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (vfid == VFID_BITS'(i)) begin
                full_sel = full[i];
            end
        end
    end

    // Ready depends only on registered occupancy, never on m_meta_ready, so a
    // full queue stalls the input even in a cycle where it is being popped.
    assign s_meta_ready = (DROP_MODE != 0) ? 1'b1 : ~full_sel;
    assign in_acc       = s_meta_valid & s_meta_ready & ~areset;
    assign drop         = in_acc & (~tgt_ok | full_sel);

    always_comb begin
        push = '0;
        for (int i = 0; i < N_CH; i++) begin
            push[i] = in_acc & (vfid == VFID_BITS'(i)) & ~full[i];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        meta_fifo #(
            .W     (DATA_BITS),
            .DEPTH (DEPTH)
        ) u_fifo (
            .core_clk (aclk),
            .rst      (areset),
            .wr_vld   (push[g]),
            .wr_dat   (s_meta_data),
            .full     (full[g]),
            .rd_vld   (m_meta_valid[g]),
            .rd_rdy   (m_meta_ready[g]),
            .rd_dat   (m_meta_data[g*DATA_BITS +: DATA_BITS]),
            .cnt      (fill[g*CNT_W +: CNT_W])
        );
    end

    // A clear coinciding with a drop keeps that drop, so the counter lands on 1.
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt <= '0;
        end else if (drop_cnt_clr) begin
            drop_cnt <= drop ? 32'd1 : 32'd0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_rdma_meta_rx_demux_q.sv
// Purpose: checks rdma_meta_rx_demux_q in both drop modes against a queue-based model.
// Latency: outputs sampled on the falling edge; model advances once per rising edge.
// Backpressure: the stream advances only when the mode-0 model says the word is taken.
module tb_rdma_meta_rx_demux_q;
    localparam int NC = 4;
    localparam int DW = 40;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic          s_meta_valid;
    logic [DW-1:0] s_meta_data;
    logic [NC-1:0] m_meta_ready;
    logic          drop_cnt_clr;

    logic          s_meta_ready0, s_meta_ready1;
    logic [NC-1:0] m_meta_valid0, m_meta_valid1;
    logic [NC*DW-1:0] m_meta_data0, m_meta_data1;
    logic [3:0]    vfid0, vfid1;
    logic [19:0]   fill0, fill1;
    logic [31:0]   drop_cnt0, drop_cnt1;

    always #5 clk = ~clk;

    rdma_meta_rx_demux_q #(.N_CH(NC), .DATA_BITS(DW), .VFID_LSB(4), .VFID_BITS(4),
                           .DEPTH(DP), .DROP_MODE(0)) dut0 (
        .aclk(clk), .areset(areset), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready0),
        .s_meta_data(s_meta_data), .m_meta_valid(m_meta_valid0), .m_meta_ready(m_meta_ready),
        .m_meta_data(m_meta_data0), .vfid(vfid0), .fill(fill0), .drop_cnt(drop_cnt0),
        .drop_cnt_clr(drop_cnt_clr));

    rdma_meta_rx_demux_q #(.N_CH(NC), .DATA_BITS(DW), .VFID_LSB(4), .VFID_BITS(4),
                           .DEPTH(DP), .DROP_MODE(1)) dut1 (
        .aclk(clk), .areset(areset), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready1),
        .s_meta_data(s_meta_data), .m_meta_valid(m_meta_valid1), .m_meta_ready(m_meta_ready),
        .m_meta_data(m_meta_data1), .vfid(vfid1), .fill(fill1), .drop_cnt(drop_cnt1),
        .drop_cnt_clr(drop_cnt_clr));

    // Reference model: one queue per (dut, channel), index d*NC+ch, plus a drop counter per dut.
    logic [DW-1:0] mq [2*NC][$];
    logic [31:0]   mdrop [2];
    int            total = 0;
    int            bad = 0;

    typedef struct {
        bit         vld;
        int         idx;
        int         vf;
        logic [3:0] mrdy;
        bit         clr;
        bit         exp_srdy;
        logic [3:0] exp_mv;
        int         exp_ch;
        logic [DW-1:0] exp_dat;
        logic [31:0] exp_drop;
    } vec_t;
    vec_t tbl [$];

    function automatic logic [DW-1:0] mk(input int idx, input int vf);
        logic [DW-1:0] r;
        r = '0;
        r[39:16] = idx[23:0];
        r[7:4]   = vf[3:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit d_srdy(input int d);
        return (d != 0) ? s_meta_ready1 : s_meta_ready0;
    endfunction
    function automatic logic [3:0] d_mv(input int d);
        return (d != 0) ? m_meta_valid1 : m_meta_valid0;
    endfunction
    function automatic logic [NC*DW-1:0] d_dat(input int d);
        return (d != 0) ? m_meta_data1 : m_meta_data0;
    endfunction
    function automatic logic [19:0] d_fill(input int d);
        return (d != 0) ? fill1 : fill0;
    endfunction
    function automatic logic [31:0] d_drop(input int d);
        return (d != 0) ? drop_cnt1 : drop_cnt0;
    endfunction

    // Expected ready from the rules: out-of-range VFID or drop mode -> 1, else not full.
    function automatic bit exp_rdy(input int d);
        int vf;
        vf = int'(s_meta_data[7:4]);
        if (vf >= NC || d == 1) return 1'b1;
        return mq[d*NC+vf].size() != DP;
    endfunction

    // Called at the falling edge: compare everything, advance the model, move past the next rising edge.
    task automatic step(output bit acc0);
        logic [3:0]  ev;
        logic [19:0] ef;
        int          vf;
        bit          pushit, dropit;
        for (int d = 0; d < 2; d++) begin
            ev = '0;
            ef = '0;
            for (int c = 0; c < NC; c++) begin
                ev[c] = mq[d*NC+c].size() > 0;
                ef[c*5 +: 5] = 5'(mq[d*NC+c].size());
            end
            chk($sformatf("d%0d s_meta_ready", d), 64'(d_srdy(d)), 64'(exp_rdy(d)));
            chk($sformatf("d%0d vfid", d), 64'((d != 0) ? vfid1 : vfid0), 64'(s_meta_data[7:4]));
            chk($sformatf("d%0d m_meta_valid", d), 64'(d_mv(d)), 64'(ev));
            chk($sformatf("d%0d fill", d), 64'(d_fill(d)), 64'(ef));
            chk($sformatf("d%0d drop_cnt", d), 64'(d_drop(d)), 64'(mdrop[d]));
            for (int c = 0; c < NC; c++) begin
                if (mq[d*NC+c].size() > 0) begin
                    chk($sformatf("d%0d ch%0d data", d, c), 64'(d_dat(d)[c*DW +: DW]), 64'(mq[d*NC+c][0]));
                end
            end
        end
        acc0 = s_meta_valid && exp_rdy(0) && !areset;
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                for (int c = 0; c < NC; c++) mq[d*NC+c].delete();
                mdrop[d] = '0;
            end else begin
                vf = int'(s_meta_data[7:4]);
                pushit = 1'b0;
                dropit = 1'b0;
                if (s_meta_valid && exp_rdy(d)) begin
                    if (vf >= NC || mq[d*NC+vf].size() == DP) dropit = 1'b1;
                    else pushit = 1'b1;
                end
                for (int c = 0; c < NC; c++) begin
                    if (mq[d*NC+c].size() > 0 && m_meta_ready[c]) void'(mq[d*NC+c].pop_front());
                end
                if (pushit) mq[d*NC+vf].push_back(s_meta_data);
                if (drop_cnt_clr) mdrop[d] = dropit ? 32'd1 : 32'd0;
                else if (dropit && mdrop[d] != 32'hFFFF_FFFF) mdrop[d] = mdrop[d] + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(output bit acc0);
        @(negedge clk);
        step(acc0);
    endtask

    task automatic drain(input int n);
        bit a;
        s_meta_valid = 1'b0;
        m_meta_ready = 4'hF;
        for (int i = 0; i < n; i++) run(a);
    endtask

    initial begin
        bit   acc;
        int   k;
        int   guard;
        logic [3:0] mrdy_r;
        int   vf;

        areset = 1'b1;
        s_meta_valid = 1'b0;
        s_meta_data = '0;
        m_meta_ready = 4'hF;
        drop_cnt_clr = 1'b0;
        mdrop[0] = '0;
        mdrop[1] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("reset fill", 64'(fill0), 64'h0);
        chk("reset m_meta_valid", 64'(m_meta_valid0 | m_meta_valid1), 64'h0);
        chk("reset drop_cnt", 64'(drop_cnt0 | drop_cnt1), 64'h0);
        step(acc);

        // Routing vectors followed by invalid-VFID / clear vectors.
        for (int i = 0; i < 10; i++) begin
            int p;
            p = (i + 3) % 4;
            tbl.push_back('{i < 8, i, i % 4, 4'hF, 1'b0, 1'b1,
                            (i == 0 || i == 9) ? 4'h0 : 4'(1 << p), p, mk(i - 1, p), 32'd0});
        end
        tbl.push_back('{1'b1, 100, 5, 4'hF, 1'b0, 1'b1, 4'h0, 0, '0, 32'd0});
        tbl.push_back('{1'b0, 0, 0, 4'hF, 1'b0, 1'b1, 4'h0, 0, '0, 32'd1});
        tbl.push_back('{1'b1, 101, 9, 4'hF, 1'b1, 1'b1, 4'h0, 0, '0, 32'd1});
        tbl.push_back('{1'b0, 0, 0, 4'hF, 1'b0, 1'b1, 4'h0, 0, '0, 32'd1});
        tbl.push_back('{1'b0, 0, 0, 4'hF, 1'b1, 1'b1, 4'h0, 0, '0, 32'd1});
        tbl.push_back('{1'b0, 0, 0, 4'hF, 1'b0, 1'b1, 4'h0, 0, '0, 32'd0});
        foreach (tbl[i]) begin
            s_meta_valid = tbl[i].vld;
            s_meta_data  = mk(tbl[i].idx, tbl[i].vf);
            m_meta_ready = tbl[i].mrdy;
            drop_cnt_clr = tbl[i].clr;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tbl%0d d%0d s_meta_ready", i, d), 64'(d_srdy(d)), 64'(tbl[i].exp_srdy));
                chk($sformatf("tbl%0d d%0d m_meta_valid", i, d), 64'(d_mv(d)), 64'(tbl[i].exp_mv));
                chk($sformatf("tbl%0d d%0d drop_cnt", i, d), 64'(d_drop(d)), 64'(tbl[i].exp_drop));
                if (tbl[i].exp_mv != 0)
                    chk($sformatf("tbl%0d d%0d data", i, d),
                        64'(d_dat(d)[tbl[i].exp_ch*DW +: DW]), 64'(tbl[i].exp_dat));
            end
            step(acc);
        end
        drop_cnt_clr = 1'b0;

        // Backpressure on channel 2.
        m_meta_ready = 4'b1011;
        for (int i = 0; i < 17; i++) begin
            s_meta_valid = 1'b1;
            s_meta_data  = mk(200 + i, 2);
            @(negedge clk);
            if (i == 16) begin
                chk("bp 17th ready", 64'(s_meta_ready0), 64'h0);
                chk("bp fill2", 64'(fill0[14:10]), 64'd16);
            end
            step(acc);
        end
        m_meta_ready = 4'hF;
        @(negedge clk);
        chk("bp ready while popping full", 64'(s_meta_ready0), 64'h0);
        step(acc);
        m_meta_ready = 4'b1011;
        @(negedge clk);
        chk("bp ready after pop", 64'(s_meta_ready0), 64'h1);
        chk("bp fill2 after pop", 64'(fill0[14:10]), 64'd15);
        step(acc);
        s_meta_valid = 1'b0;
        @(negedge clk);
        chk("bp fill2 refilled", 64'(fill0[14:10]), 64'd16);
        step(acc);
        drain(20);

        // Drop mode on channel 1.
        drop_cnt_clr = 1'b1;
        run(acc);
        drop_cnt_clr = 1'b0;
        m_meta_ready = 4'b1101;
        for (int i = 0; i < 19; i++) begin
            s_meta_valid = 1'b1;
            s_meta_data  = mk(400 + i, 1);
            run(acc);
        end
        s_meta_valid = 1'b0;
        @(negedge clk);
        chk("drop mode drop_cnt", 64'(drop_cnt1), 64'd3);
        chk("drop mode fill1", 64'(fill1[9:5]), 64'd16);
        chk("stall mode drop_cnt", 64'(drop_cnt0), 64'd0);
        step(acc);
        drain(20);

        // Wrap with toggling ready on channel 0.
        k = 0;
        guard = 0;
        while (k < 40 && guard < 400) begin
            s_meta_valid = 1'b1;
            s_meta_data  = mk(300 + k, 0);
            m_meta_ready = {3'b111, guard[0] == 1'b0};
            @(negedge clk);
            if (fill0[4:0] > 5'd16) chk("wrap fill0 bound", 64'(fill0[4:0]), 64'd16);
            step(acc);
            if (acc) k++;
            guard++;
        end
        chk("wrap words sent", 64'(k), 64'd40);
        drain(40);

        // Reset mid-run with 5 words on channel 3.
        m_meta_ready = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            s_meta_valid = 1'b1;
            s_meta_data  = mk(500 + i, 3);
            run(acc);
        end
        s_meta_valid = 1'b0;
        areset = 1'b1;
        run(acc);
        areset = 1'b0;
        @(negedge clk);
        chk("rst m_meta_valid", 64'(m_meta_valid0 | m_meta_valid1), 64'h0);
        chk("rst fill", 64'(fill0 | fill1), 64'h0);
        step(acc);
        m_meta_ready = 4'hF;
        s_meta_valid = 1'b1;
        s_meta_data  = mk(600, 3);
        run(acc);
        s_meta_valid = 1'b0;
        @(negedge clk);
        chk("post rst valid", 64'(m_meta_valid0), 64'h8);
        chk("post rst data", 64'(m_meta_data0[3*DW +: DW]), 64'(mk(600, 3)));
        step(acc);
        @(negedge clk);
        chk("post rst alone", 64'(m_meta_valid0), 64'h0);
        step(acc);

        // Randomized traffic with occasional clears and resets.
        acc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!s_meta_valid || acc) begin
                s_meta_valid = ($urandom_range(0, 3) != 0);
                vf = $urandom_range(0, 6);
                s_meta_data = {8'($urandom), 32'($urandom)};
                s_meta_data[7:4] = 4'(vf);
            end
            mrdy_r = ((i / 300) % 2 != 0) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
            m_meta_ready = mrdy_r;
            drop_cnt_clr = ($urandom_range(0, 40) == 0);
            areset = ($urandom_range(0, 400) == 0);
            run(acc);
        end
        areset = 1'b0;
        drop_cnt_clr = 1'b0;
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
